mul_pipeline: RTL and testbench
===============================

// Module: mul_pipeline
// PURPOSE
// - Five-stage integer multiply pipeline (EX1..EX5), directly downstream of decode.
// - Consumes decode's ex_valid_o, bypassed rs1/rs2 data and wr_reg.
// - Exposes per-stage valid/wr_reg so hazard logic can detect MUL RAW dependencies.
// - Exposes the EX5 result so decode can bypass it and writeback can commit it.
// PARAMETERS
// - DATA_WIDTH      32  operand/result width (params_pkg::DATA_WIDTH)
// - REGISTER_WIDTH   5  destination register index width (params_pkg::REGISTER_WIDTH)
// PORTS
// - clk_i                 in   1        clock; all state updates on rising edge
// - rst_i                 in   1        synchronous reset, active-high
// - valid_i               in   1        MUL issued this cycle (decode ex_valid_o)
// - stall_i               in   1        freeze all stages (hazard unit)
// - rs1_data_i            in   DW       bypassed operand A (decode alu_rs1_data_o)
// - rs2_data_i            in   DW       bypassed operand B (decode alu_rs2_data_o)
// - wr_reg_i              in   RW       destination register
// - exN_valid_o  N=1..5   out  1        stage N holds a live MUL
// - exN_wr_reg_o N=1..5   out  RW       stage N destination register
// - ex5_result_o          out  DW       product of the op in EX5; 0 when ex5_valid_o=0
// BEHAVIOUR
// - Reset: clock/reset and polarity are fixed: one clock clk_i; rst_i synchronous, active-high.
//   - While rst_i=1, every exN_valid_o, exN_wr_reg_o, ex5_result_o and internal data register is set to 0 at the edge.
//   - rst_i has priority over stall_i and valid_i; an op in flight when reset asserts is dropped.
// - Advance (stall_i=0), each edge:
//   - EX1 <= {valid_i, wr_reg_i, rs1_data_i, rs2_data_i}
//   - EXk <= EX(k-1) for k=2..5
//   - An op issued in cycle t shows ex5_valid_o=1 in cycle t+5.
//   - Back-to-back issue gives one result per cycle.
// - Stall (stall_i=1): every stage register holds its value; valid_i is ignored (decode holds the instruction).
// - Datapath split (registered boundaries):
//   - EX1 latches operands.
//   - EX2 computes the four unsigned 16x16 partial products.
//   - EX3 sums them into a 2*DW product.
//   - EX4 selects the result word.
//   - EX5 registers the final result.
//   - ex5_result_o is a pure register output, no combinational logic after EX5.
// - Arithmetic:
//   - Default result is the low DW bits of A*B; identical for signed and unsigned.
//   - Overflow wraps silently.
// - x0 destination: an op with wr_reg_i=0 still flows with valid=1, but its result is forced to 0.
//   Decode forwarding of x0 therefore stays architecturally correct.
// - Bubbles: a stage with valid=0 keeps data registers at 0, so ex5_result_o=0 whenever ex5_valid_o=0.
// - No flush input: ops in the pipe are always older than any branch, so decode squashes before issue.
// CONFIGURATION
// - MUL_HIGH_EN defined:
//   - Adds port funct3_i (in, 3), carried alongside wr_reg.
//   - EX2 sign-extends operands to 2*DW per funct3:
//     - 000 MUL: low word
//     - 001 MULH: signed x signed, high word
//     - 010 MULHSU: signed x unsigned, high word
//     - 011 MULHU: unsigned x unsigned, high word
//   - Any other funct3 value gives the low word.
// - MUL_HIGH_EN undefined: funct3_i absent; low word only; high-word logic not synthesized.
// TESTING
// - Single op: A=7, B=6, rd=5, stall_i=0 -> ex1..ex5_valid_o pulse in cycles t+1..t+5; ex5_result_o=42; ex5_wr_reg_o=5.
// - Back-to-back ops:
//   - Stimulus: (3,4,rd1), (0xFFFFFFFF,2,rd2), (0x10000,0x10000,rd3) on consecutive cycles.
//   - Response: results 12, 0xFFFFFFFE, 0x00000000 on consecutive cycles t+5..t+7.
// - Stall: op in EX3 with stall_i=1 for 3 cycles -> all exN outputs frozen; ex5_valid_o appears 3 cycles late; result unchanged.
// - x0 and reset:
//   - A=9, B=9, rd=0 -> ex5_valid_o=1, ex5_result_o=0.
//   - rst_i=1 while ops sit in EX2 and EX4 -> next cycle all valids 0, all outputs 0.
// - MUL_HIGH_EN, A=0xFFFFFFFF, B=2:
//   - funct3 001 -> 0xFFFFFFFF
//   - funct3 011 -> 0x00000001
//   - funct3 010 -> 0xFFFFFFFF
//   - funct3 000 -> 0xFFFFFFFE

Source files
------------

// File: rtl/mul_pipeline.sv
// mul_pipeline: five-stage integer multiplier (EX1..EX5) fed by decode.
//   EX1 latches operands, EX2 forms four half-width partial products,
//   EX3 sums them into a double-width product, EX4 picks the result word,
//   EX5 holds the final registered result.
// Optional feature macro: MUL_HIGH_EN adds funct3_i and MULH/MULHSU/MULHU.
// Stages holding a bubble keep all their data registers at zero, so the
// result output is zero whenever ex5_valid_o is low.
module mul_pipeline #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    input  logic                      stall_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
`ifdef MUL_HIGH_EN
    input  logic [2:0]                funct3_i,
`endif
    output logic                      ex1_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
    output logic                      ex2_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
    output logic                      ex3_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
    output logic                      ex4_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
    output logic                      ex5_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex5_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     ex5_result_o
);

    localparam int DW = DATA_WIDTH;
    localparam int RW = REGISTER_WIDTH;
    localparam int HW = DATA_WIDTH / 2;
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [DW-1:0] ZERO_DW = {DW{1'b0}};
    localparam logic [RW-1:0] ZERO_RW = {RW{1'b0}};
    localparam logic [PW-1:0] ZERO_PW = {PW{1'b0}};

    // Stage EX1: latched operands
    logic          ex1_valid_d, ex1_valid_q;
    logic [RW-1:0] ex1_rd_d,    ex1_rd_q;
    logic [DW-1:0] ex1_a_d,     ex1_a_q;
    logic [DW-1:0] ex1_b_d,     ex1_b_q;
    // Stage EX2: partial products
    logic          ex2_valid_d, ex2_valid_q;
    logic [RW-1:0] ex2_rd_d,    ex2_rd_q;
    logic [DW-1:0] ex2_pp_ll_d, ex2_pp_ll_q;
    logic [DW-1:0] ex2_pp_lh_d, ex2_pp_lh_q;
    logic [DW-1:0] ex2_pp_hl_d, ex2_pp_hl_q;
    logic [DW-1:0] ex2_pp_hh_d, ex2_pp_hh_q;
    // Stage EX3: full double-width product
    logic          ex3_valid_d, ex3_valid_q;
    logic [RW-1:0] ex3_rd_d,    ex3_rd_q;
    logic [PW-1:0] ex3_prod_d,  ex3_prod_q;
    // Stage EX4: selected result word
    logic          ex4_valid_d, ex4_valid_q;
    logic [RW-1:0] ex4_rd_d,    ex4_rd_q;
    logic [DW-1:0] ex4_res_d,   ex4_res_q;
    // Stage EX5: final result
    logic          ex5_valid_d, ex5_valid_q;
    logic [RW-1:0] ex5_rd_d,    ex5_rd_q;
    logic [DW-1:0] ex5_res_d,   ex5_res_q;

`ifdef MUL_HIGH_EN
    // High-word support: funct3 travels with the op into EX2, after which
    // only the word select and the signed correction term are needed.
    logic [2:0]    ex1_f3_d,    ex1_f3_q;
    logic          ex2_hi_d,    ex2_hi_q;
    logic [DW-1:0] ex2_corr_d,  ex2_corr_q;
    logic          ex3_hi_d,    ex3_hi_q;
    logic          a_signed_s;
    logic          b_signed_s;
`endif

    // EX1 next state: capture the issued op, or a zeroed bubble
    always_comb begin
        ex1_valid_d = ex1_valid_q;
        ex1_rd_d    = ex1_rd_q;
        ex1_a_d     = ex1_a_q;
        ex1_b_d     = ex1_b_q;
`ifdef MUL_HIGH_EN
        ex1_f3_d    = ex1_f3_q;
`endif
        if (!stall_i) begin
            ex1_valid_d = valid_i;
            if (valid_i) begin
                ex1_rd_d = wr_reg_i;
                ex1_a_d  = rs1_data_i;
                ex1_b_d  = rs2_data_i;
`ifdef MUL_HIGH_EN
                ex1_f3_d = funct3_i;
`endif
            end else begin
                ex1_rd_d = ZERO_RW;
                ex1_a_d  = ZERO_DW;
                ex1_b_d  = ZERO_DW;
`ifdef MUL_HIGH_EN
                ex1_f3_d = 3'b000;
`endif
            end
        end else begin
            // stalled: decode holds the instruction, EX1 keeps its contents
            ex1_valid_d = ex1_valid_q;
        end
    end

`ifdef MUL_HIGH_EN
    // EX2 operand signedness decode from funct3
    always_comb begin
        case (ex1_f3_q)
            3'b001:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            3'b010:  begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            default: begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
    end
`endif

    // EX2 next state: four unsigned half-width partial products
    always_comb begin
        ex2_valid_d = ex2_valid_q;
        ex2_rd_d    = ex2_rd_q;
        ex2_pp_ll_d = ex2_pp_ll_q;
        ex2_pp_lh_d = ex2_pp_lh_q;
        ex2_pp_hl_d = ex2_pp_hl_q;
        ex2_pp_hh_d = ex2_pp_hh_q;
`ifdef MUL_HIGH_EN
        ex2_hi_d    = ex2_hi_q;
        ex2_corr_d  = ex2_corr_q;
`endif
        if (!stall_i) begin
            ex2_valid_d = ex1_valid_q;
            if (ex1_valid_q) begin
                ex2_rd_d    = ex1_rd_q;
                ex2_pp_ll_d = DW'(ex1_a_q[HW-1:0]) * DW'(ex1_b_q[HW-1:0]);
                ex2_pp_lh_d = DW'(ex1_a_q[HW-1:0]) * DW'(ex1_b_q[DW-1:HW]);
                ex2_pp_hl_d = DW'(ex1_a_q[DW-1:HW]) * DW'(ex1_b_q[HW-1:0]);
                ex2_pp_hh_d = DW'(ex1_a_q[DW-1:HW]) * DW'(ex1_b_q[DW-1:HW]);
`ifdef MUL_HIGH_EN
                // Sign-extending an operand to 2*DW adds (2^DW - 1) * other
                // operand into the upper word when it is negative; modulo
                // 2^(2*DW) that is "subtract other << DW", gathered here.
                ex2_hi_d   = (ex1_f3_q == 3'b001) || (ex1_f3_q == 3'b010) ||
                             (ex1_f3_q == 3'b011);
                ex2_corr_d = ((a_signed_s && ex1_a_q[DW-1]) ? ex1_b_q : ZERO_DW) +
                             ((b_signed_s && ex1_b_q[DW-1]) ? ex1_a_q : ZERO_DW);
`endif
            end else begin
                ex2_rd_d    = ZERO_RW;
                ex2_pp_ll_d = ZERO_DW;
                ex2_pp_lh_d = ZERO_DW;
                ex2_pp_hl_d = ZERO_DW;
                ex2_pp_hh_d = ZERO_DW;
`ifdef MUL_HIGH_EN
                ex2_hi_d    = 1'b0;
                ex2_corr_d  = ZERO_DW;
`endif
            end
        end else begin
            // stalled: EX2 keeps its contents
            ex2_valid_d = ex2_valid_q;
        end
    end

    // EX3 next state: sum partial products into the double-width product
    always_comb begin
        ex3_valid_d = ex3_valid_q;
        ex3_rd_d    = ex3_rd_q;
        ex3_prod_d  = ex3_prod_q;
`ifdef MUL_HIGH_EN
        ex3_hi_d    = ex3_hi_q;
`endif
        if (!stall_i) begin
            ex3_valid_d = ex2_valid_q;
            if (ex2_valid_q) begin
                ex3_rd_d   = ex2_rd_q;
                ex3_prod_d = {ex2_pp_hh_q, ex2_pp_ll_q}
                           + (PW'(ex2_pp_lh_q) << HW)
                           + (PW'(ex2_pp_hl_q) << HW);
`ifdef MUL_HIGH_EN
                ex3_prod_d = ex3_prod_d - {ex2_corr_q, ZERO_DW};
                ex3_hi_d   = ex2_hi_q;
`endif
            end else begin
                ex3_rd_d   = ZERO_RW;
                ex3_prod_d = ZERO_PW;
`ifdef MUL_HIGH_EN
                ex3_hi_d   = 1'b0;
`endif
            end
        end else begin
            // stalled: EX3 keeps its contents
            ex3_valid_d = ex3_valid_q;
        end
    end

    // EX4 next state: pick the result word; x0 destinations read as zero
    always_comb begin
        ex4_valid_d = ex4_valid_q;
        ex4_rd_d    = ex4_rd_q;
        ex4_res_d   = ex4_res_q;
        if (!stall_i) begin
            ex4_valid_d = ex3_valid_q;
            if (ex3_valid_q) begin
                ex4_rd_d = ex3_rd_q;
                if (ex3_rd_q == ZERO_RW) begin
                    ex4_res_d = ZERO_DW;
                end else begin
`ifdef MUL_HIGH_EN
                    ex4_res_d = ex3_hi_q ? ex3_prod_q[PW-1:DW] : ex3_prod_q[DW-1:0];
`else
                    ex4_res_d = ex3_prod_q[DW-1:0];
`endif
                end
            end else begin
                ex4_rd_d  = ZERO_RW;
                ex4_res_d = ZERO_DW;
            end
        end else begin
            // stalled: EX4 keeps its contents
            ex4_valid_d = ex4_valid_q;
        end
    end

    // EX5 next state: register the final result unchanged
    always_comb begin
        ex5_valid_d = ex5_valid_q;
        ex5_rd_d    = ex5_rd_q;
        ex5_res_d   = ex5_res_q;
        if (!stall_i) begin
            ex5_valid_d = ex4_valid_q;
            if (ex4_valid_q) begin
                ex5_rd_d  = ex4_rd_q;
                ex5_res_d = ex4_res_q;
            end else begin
                ex5_rd_d  = ZERO_RW;
                ex5_res_d = ZERO_DW;
            end
        end else begin
            // stalled: EX5 keeps its contents
            ex5_valid_d = ex5_valid_q;
        end
    end

    // Pipeline registers; reset drops every op in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex1_valid_q <= 1'b0;
            ex1_rd_q    <= ZERO_RW;
            ex1_a_q     <= ZERO_DW;
            ex1_b_q     <= ZERO_DW;
            ex2_valid_q <= 1'b0;
            ex2_rd_q    <= ZERO_RW;
            ex2_pp_ll_q <= ZERO_DW;
            ex2_pp_lh_q <= ZERO_DW;
            ex2_pp_hl_q <= ZERO_DW;
            ex2_pp_hh_q <= ZERO_DW;
            ex3_valid_q <= 1'b0;
            ex3_rd_q    <= ZERO_RW;
            ex3_prod_q  <= ZERO_PW;
            ex4_valid_q <= 1'b0;
            ex4_rd_q    <= ZERO_RW;
            ex4_res_q   <= ZERO_DW;
            ex5_valid_q <= 1'b0;
            ex5_rd_q    <= ZERO_RW;
            ex5_res_q   <= ZERO_DW;
`ifdef MUL_HIGH_EN
            ex1_f3_q    <= 3'b000;
            ex2_hi_q    <= 1'b0;
            ex2_corr_q  <= ZERO_DW;
            ex3_hi_q    <= 1'b0;
`endif
        end else begin
            ex1_valid_q <= ex1_valid_d;
            ex1_rd_q    <= ex1_rd_d;
            ex1_a_q     <= ex1_a_d;
            ex1_b_q     <= ex1_b_d;
            ex2_valid_q <= ex2_valid_d;
            ex2_rd_q    <= ex2_rd_d;
            ex2_pp_ll_q <= ex2_pp_ll_d;
            ex2_pp_lh_q <= ex2_pp_lh_d;
            ex2_pp_hl_q <= ex2_pp_hl_d;
            ex2_pp_hh_q <= ex2_pp_hh_d;
            ex3_valid_q <= ex3_valid_d;
            ex3_rd_q    <= ex3_rd_d;
            ex3_prod_q  <= ex3_prod_d;
            ex4_valid_q <= ex4_valid_d;
            ex4_rd_q    <= ex4_rd_d;
            ex4_res_q   <= ex4_res_d;
            ex5_valid_q <= ex5_valid_d;
            ex5_rd_q    <= ex5_rd_d;
            ex5_res_q   <= ex5_res_d;
`ifdef MUL_HIGH_EN
            ex1_f3_q    <= ex1_f3_d;
            ex2_hi_q    <= ex2_hi_d;
            ex2_corr_q  <= ex2_corr_d;
            ex3_hi_q    <= ex3_hi_d;
`endif
        end
    end

    assign ex1_valid_o  = ex1_valid_q;
    assign ex1_wr_reg_o = ex1_rd_q;
    assign ex2_valid_o  = ex2_valid_q;
    assign ex2_wr_reg_o = ex2_rd_q;
    assign ex3_valid_o  = ex3_valid_q;
    assign ex3_wr_reg_o = ex3_rd_q;
    assign ex4_valid_o  = ex4_valid_q;
    assign ex4_wr_reg_o = ex4_rd_q;
    assign ex5_valid_o  = ex5_valid_q;
    assign ex5_wr_reg_o = ex5_rd_q;
    assign ex5_result_o = ex5_res_q;

endmodule

// File: tb/tb_mul_pipeline.sv
// tb_mul_pipeline: directed scenarios plus randomized traffic for
// mul_pipeline, compared every cycle against a stage-occupancy model whose
// results come straight from 64-bit arithmetic.
module tb_mul_pipeline;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          stall;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [RW-1:0] rd;
    logic [2:0]    f3;

    logic          ex1_v, ex2_v, ex3_v, ex4_v, ex5_v;
    logic [RW-1:0] ex1_rd, ex2_rd, ex3_rd, ex4_rd, ex5_rd;
    logic [DW-1:0] ex5_res;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          v;
        bit [RW-1:0] rd;
        bit [DW-1:0] res;
    } stage_t;

    stage_t m [1:5];

    logic [5:1]    obs_v;
    logic [RW-1:0] obs_rd [1:5];

    always #5 clk = ~clk;

    mul_pipeline #(.DATA_WIDTH(DW), .REGISTER_WIDTH(RW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid),
        .stall_i      (stall),
        .rs1_data_i   (rs1),
        .rs2_data_i   (rs2),
        .wr_reg_i     (rd),
`ifdef MUL_HIGH_EN
        .funct3_i     (f3),
`endif
        .ex1_valid_o  (ex1_v),
        .ex1_wr_reg_o (ex1_rd),
        .ex2_valid_o  (ex2_v),
        .ex2_wr_reg_o (ex2_rd),
        .ex3_valid_o  (ex3_v),
        .ex3_wr_reg_o (ex3_rd),
        .ex4_valid_o  (ex4_v),
        .ex4_wr_reg_o (ex4_rd),
        .ex5_valid_o  (ex5_v),
        .ex5_wr_reg_o (ex5_rd),
        .ex5_result_o (ex5_res)
    );

    assign obs_v     = {ex5_v, ex4_v, ex3_v, ex2_v, ex1_v};
    assign obs_rd[1] = ex1_rd;
    assign obs_rd[2] = ex2_rd;
    assign obs_rd[3] = ex3_rd;
    assign obs_rd[4] = ex4_rd;
    assign obs_rd[5] = ex5_rd;

    // Architectural result of one multiply
    function automatic bit [DW-1:0] ref_result(bit [DW-1:0] a, bit [DW-1:0] b,
                                               bit [RW-1:0] dst, bit [2:0] fn);
        longint   sa;
        longint   sb;
        longint   ub;
        bit [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        p  = {32'h0, a} * {32'h0, b};
`ifdef MUL_HIGH_EN
        case (fn)
            3'b001:  p = 64'(sa * sb) >> 32;
            3'b010:  p = 64'(sa * ub) >> 32;
            3'b011:  p = p >> 32;
            default: p = p;
        endcase
`endif
        if (dst == 5'd0) return 32'h0;
        return p[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare
    task automatic step();
        @(posedge clk);
        if (rst) begin
            for (int k = 1; k <= 5; k++) m[k] = '{1'b0, 5'd0, 32'h0};
        end else if (!stall) begin
            for (int k = 5; k >= 2; k--) m[k] = m[k-1];
            if (valid) m[1] = '{1'b1, rd, ref_result(rs1, rs2, rd, f3)};
            else       m[1] = '{1'b0, 5'd0, 32'h0};
        end
        #1;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("ex%0d_valid", k), 64'(obs_v[k]), 64'(m[k].v));
            if (m[k].v) check($sformatf("ex%0d_wr_reg", k), 64'(obs_rd[k]), 64'(m[k].rd));
        end
        check("ex5_result", 64'(ex5_res), 64'(m[5].res));
    endtask

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [RW-1:0] dst, input logic [2:0] fn);
        valid = 1'b1;
        rs1   = a;
        rs2   = b;
        rd    = dst;
        f3    = fn;
        step();
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [DW-1:0] corner [0:5];
        corner[0] = 32'h0;          corner[1] = 32'h1;
        corner[2] = 32'hFFFF_FFFF;  corner[3] = 32'h8000_0000;
        corner[4] = 32'h0001_0000;  corner[5] = 32'h7FFF_FFFF;

        for (int k = 1; k <= 5; k++) m[k] = '{1'b0, 5'd0, 32'h0};
        rst = 1'b1; valid = 1'b0; stall = 1'b0;
        rs1 = 32'h0; rs2 = 32'h0; rd = 5'd0; f3 = 3'b000;
        idle(2);
        check("reset_v5", 64'(ex5_v), 64'd0);
        check("reset_res", 64'(ex5_res), 64'd0);
        rst = 1'b0;
        idle(1);

        // single op 7*6 -> 42 five edges after issue
        issue(32'd7, 32'd6, 5'd5, 3'b000);
        check("single_ex1_v", 64'(ex1_v), 64'd1);
        idle(4);
        check("single_v5", 64'(ex5_v), 64'd1);
        check("single_res", 64'(ex5_res), 64'd42);
        check("single_rd", 64'(ex5_rd), 64'd5);
        idle(1);

        // back-to-back ops, one result per cycle
        issue(32'd3, 32'd4, 5'd1, 3'b000);
        issue(32'hFFFF_FFFF, 32'd2, 5'd2, 3'b000);
        issue(32'h0001_0000, 32'h0001_0000, 5'd3, 3'b000);
        idle(2);
        check("b2b_res0", 64'(ex5_res), 64'd12);
        idle(1);
        check("b2b_res1", 64'(ex5_res), 64'hFFFF_FFFE);
        idle(1);
        check("b2b_v2", 64'(ex5_v), 64'd1);
        check("b2b_res2", 64'(ex5_res), 64'h0);
        idle(2);

        // stall while the op sits in EX3
        issue(32'd5, 32'd5, 5'd7, 3'b000);
        idle(2);
        check("stall_in_ex3", 64'(ex3_v), 64'd1);
        stall = 1'b1;
        valid = 1'b1; rs1 = 32'd100; rs2 = 32'd100; rd = 5'd9;
        idle(3);
        check("stall_ex3_hold", 64'(ex3_v), 64'd1);
        check("stall_ex5_idle", 64'(ex5_v), 64'd0);
        check("stall_ex1_ignored", 64'(ex1_v), 64'd0);
        stall = 1'b0; valid = 1'b0;
        idle(2);
        check("stall_v5", 64'(ex5_v), 64'd1);
        check("stall_res", 64'(ex5_res), 64'd25);
        idle(1);

        // x0 destination still flows but yields zero
        issue(32'd9, 32'd9, 5'd0, 3'b000);
        idle(4);
        check("x0_v5", 64'(ex5_v), 64'd1);
        check("x0_res", 64'(ex5_res), 64'd0);
        idle(1);

        // reset with ops sitting in EX2 and EX4
        issue(32'd11, 32'd13, 5'd4, 3'b000);
        idle(1);
        issue(32'd17, 32'd19, 5'd6, 3'b000);
        idle(1);
        check("rst_pre_ex4", 64'(ex4_v), 64'd1);
        check("rst_pre_ex2", 64'(ex2_v), 64'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_valids", 64'(obs_v), 64'd0);
        check("rst_res", 64'(ex5_res), 64'd0);
        idle(5);

`ifdef MUL_HIGH_EN
        // high-word variants with A=-1, B=2
        issue(32'hFFFF_FFFF, 32'd2, 5'd8, 3'b001);
        issue(32'hFFFF_FFFF, 32'd2, 5'd8, 3'b011);
        issue(32'hFFFF_FFFF, 32'd2, 5'd8, 3'b010);
        issue(32'hFFFF_FFFF, 32'd2, 5'd8, 3'b000);
        idle(1);
        check("mulh_res", 64'(ex5_res), 64'hFFFF_FFFF);
        idle(1);
        check("mulhu_res", 64'(ex5_res), 64'h1);
        idle(1);
        check("mulhsu_res", 64'(ex5_res), 64'hFFFF_FFFF);
        idle(1);
        check("mul_res", 64'(ex5_res), 64'hFFFF_FFFE);
        idle(2);
`endif

        // randomized traffic with stalls, x0 and occasional reset
        for (int c = 0; c < 600; c++) begin
            valid = ($urandom_range(0, 9) < 6);
            stall = ($urandom_range(0, 9) < 2);
            rst   = ($urandom_range(0, 59) == 0);
            rs1   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rs2   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            f3    = 3'($urandom);
            step();
        end
        rst = 1'b0; valid = 1'b0; stall = 1'b0;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
